// File: rtl/rs_pe_pkg.sv
// Shared defaults and state encoding for the row-stationary PE.
package rs_pe_pkg;

  localparam int BITWIDTH_DEF      = 16;
  localparam int RF_ADDR_WIDTH_DEF = 3;
  localparam int KERNEL_SIZE_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

endpackage

// File: rtl/rs_pe_if.sv
// Write/psum bundle of one PE; master drives samples and the psum from below.
interface rs_pe_if #(
  parameter int BITWIDTH = 16
);
  logic                ifmap_enable;
  logic                filter_enable;
  logic                ready;
  logic [BITWIDTH-1:0] ifmap;
  logic [BITWIDTH-1:0] filter;
  logic [BITWIDTH-1:0] input_psum;
  logic [BITWIDTH-1:0] output_psum;

  modport master (
    output ifmap_enable, filter_enable, ifmap, filter, input_psum,
    input  ready, output_psum
  );

  modport slave (
    input  ifmap_enable, filter_enable, ifmap, filter, input_psum,
    output ready, output_psum
  );
endinterface

// File: rtl/rs_pe_window_rf.sv
// Sliding-window register file: appends until full, then shifts out tap 0 on each write.
module pe_window_rf
  import rs_pe_pkg::*;
#(
  parameter int BITWIDTH      = BITWIDTH_DEF,
  parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     we_i,
  input  logic [BITWIDTH-1:0]      wdata_i,
  input  logic [RF_ADDR_WIDTH-1:0] raddr_i,
  output logic [BITWIDTH-1:0]      rdata_o,
  output logic                     full_o,
  output logic [RF_ADDR_WIDTH:0]   count_o
);

  logic [BITWIDTH-1:0]    mem_q [KERNEL_SIZE];
  logic [BITWIDTH-1:0]    mem_d [KERNEL_SIZE];
  logic [RF_ADDR_WIDTH:0] count_q;
  logic [RF_ADDR_WIDTH:0] count_d;

  assign full_o  = (count_q == (RF_ADDR_WIDTH+1)'(KERNEL_SIZE));
  assign count_o = count_q;
  assign count_d = (we_i && !full_o) ? count_q + 1'b1 : count_q;

  for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_tap
    logic [BITWIDTH-1:0] shift_in;
    if (gi == KERNEL_SIZE - 1) begin : g_last
      assign shift_in = wdata_i;
    end else begin : g_mid
      assign shift_in = mem_q[gi+1];
    end

    // Full: every tap takes its upper neighbour; filling: only the append slot moves.
    assign mem_d[gi] = !we_i                                       ? mem_q[gi] :
                       full_o                                      ? shift_in  :
                       (count_q == (RF_ADDR_WIDTH+1)'(gi))         ? wdata_i   :
                                                                     mem_q[gi];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q <= '0;
      for (int k = 0; k < KERNEL_SIZE; k++) mem_q[k] <= '0;
    end else begin
      count_q <= count_d;
      for (int k = 0; k < KERNEL_SIZE; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (raddr_i == RF_ADDR_WIDTH'(k)) rdata_o = mem_q[k];
    end
  end

endmodule

// File: rtl/rs_pe.sv
// Row-stationary PE: windowed dot product via a MAC loop, plus the psum from the PE below.
module rs_pe
  import rs_pe_pkg::*;
#(
  parameter int BITWIDTH      = BITWIDTH_DEF,
  parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF
) (
  input  logic   clk,
  input  logic   rstb,
  rs_pe_if.slave bus
);

  pe_state_e                state_q;
  logic [BITWIDTH-1:0]      acc_q;
  logic [RF_ADDR_WIDTH-1:0] tap_q;
  logic                     dirty_q;

  logic                     wr_open;
  logic                     filter_we;
  logic                     ifmap_we;
  logic [BITWIDTH-1:0]      filter_rd;
  logic [BITWIDTH-1:0]      ifmap_rd;
  logic                     filter_full;
  logic                     ifmap_full;
  logic [RF_ADDR_WIDTH:0]   filter_count;
  logic [RF_ADDR_WIDTH:0]   ifmap_count;
  logic [BITWIDTH-1:0]      prod_trunc;
  logic                     unused_counts;

  assign wr_open   = (state_q != ST_MAC);
  assign filter_we = bus.filter_enable && wr_open;
  assign ifmap_we  = bus.ifmap_enable && wr_open;

  pe_window_rf #(
    .BITWIDTH      (BITWIDTH),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE)
  ) u_filter_rf (
    .clk     (clk),
    .rstb    (rstb),
    .we_i    (filter_we),
    .wdata_i (bus.filter),
    .raddr_i (tap_q),
    .rdata_o (filter_rd),
    .full_o  (filter_full),
    .count_o (filter_count)
  );

  pe_window_rf #(
    .BITWIDTH      (BITWIDTH),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE)
  ) u_ifmap_rf (
    .clk     (clk),
    .rstb    (rstb),
    .we_i    (ifmap_we),
    .wdata_i (bus.ifmap),
    .raddr_i (tap_q),
    .rdata_o (ifmap_rd),
    .full_o  (ifmap_full),
    .count_o (ifmap_count)
  );

  assign unused_counts = ^{filter_count, ifmap_count};

  // Low BITWIDTH bits of a product are identical for signed and unsigned operands.
  assign prod_trunc = filter_rd * ifmap_rd;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (filter_full && ifmap_full && dirty_q) begin
            state_q <= ST_MAC;
            acc_q   <= '0;
            tap_q   <= '0;
            dirty_q <= 1'b0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod_trunc;
          tap_q <= tap_q + 1'b1;
          if (tap_q == RF_ADDR_WIDTH'(KERNEL_SIZE - 1)) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A write landing on the trigger edge keeps dirty so the new window is computed next.
      if (filter_we || ifmap_we) dirty_q <= 1'b1;
    end
  end

  assign bus.ready       = wr_open;
  assign bus.output_psum = (state_q == ST_DONE) ? acc_q + bus.input_psum : '0;

endmodule

// File: tb/tb_rs_pe.sv
// Three-PE lockstep column driven with directed and random windows, checked against queue-based windows.
module tb_rs_pe;
  import rs_pe_pkg::*;

  localparam int BW = 16;
  localparam int K  = 3;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic          fen [NP];
  logic          ien [NP];
  logic [BW-1:0] fv  [NP];
  logic [BW-1:0] iv  [NP];
  logic [BW-1:0] bottom;
  logic [BW-1:0] out_w [NP];
  logic          rdy_w [NP];
  logic [3:0]    fcnt  [NP];
  logic [3:0]    icnt  [NP];

  rs_pe_if #(.BITWIDTH(BW)) bus [NP] ();

  for (genvar gi = 0; gi < NP; gi++) begin : g_pe
    assign bus[gi].filter_enable = fen[gi];
    assign bus[gi].ifmap_enable  = ien[gi];
    assign bus[gi].filter        = fv[gi];
    assign bus[gi].ifmap         = iv[gi];
    if (gi == 0) begin : g_bot
      assign bus[gi].input_psum = bottom;
    end else begin : g_up
      assign bus[gi].input_psum = bus[gi-1].output_psum;
    end
    assign out_w[gi] = bus[gi].output_psum;
    assign rdy_w[gi] = bus[gi].ready;
    rs_pe u_pe (.clk(clk), .rstb(rstb), .bus(bus[gi]));
    assign fcnt[gi] = u_pe.u_filter_rf.count_o;
    assign icnt[gi] = u_pe.u_ifmap_rf.count_o;
  end

  int checks = 0;
  int errors = 0;

  // Reference windows: newest at the back, oldest dropped beyond K entries.
  logic [BW-1:0] mf [NP][$];
  logic [BW-1:0] mi [NP][$];

  function automatic logic [BW-1:0] dot(int p);
    logic [BW-1:0] s = '0;
    for (int k = 0; k < mf[p].size(); k++)
      s = s + BW'(int'($signed(mf[p][k])) * int'($signed(mi[p][k])));
    return s;
  endfunction

  function automatic logic [BW-1:0] exp_out(int p);
    logic [BW-1:0] s = bottom;
    for (int q = 0; q <= p; q++) s = s + dot(q);
    return s;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      mf[p].delete();
      mi[p].delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drive();
    for (int p = 0; p < NP; p++) begin
      fen[p] = 1'b0;
      ien[p] = 1'b0;
    end
  endtask

  task automatic commit();
    for (int p = 0; p < NP; p++) begin
      if (fen[p]) begin
        mf[p].push_back(fv[p]);
        if (mf[p].size() > K) mf[p].delete(0);
      end
      if (ien[p]) begin
        mi[p].push_back(iv[p]);
        if (mi[p].size() > K) mi[p].delete(0);
      end
    end
    tick();
    clear_drive();
  endtask

  task automatic wait_cycles(int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic do_reset();
    clear_drive();
    rstb = 1'b0;
    wait_cycles(2);
    rstb = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic check_out(string name, int p);
    logic [BW-1:0] e;
    e = exp_out(p);
    checks++;
    if (out_w[p] !== e) begin
      errors++;
      $display("FAIL %s pe%0d output_psum got %h want %h", name, p, out_w[p], e);
    end else begin
      $display("ok %s pe%0d output_psum %h", name, p, out_w[p]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rdy_w[p] !== 1'b1) begin errors++; $display("FAIL reset_ready pe%0d got %b want 1", p, rdy_w[p]); end
      checks++;
      if (out_w[p] !== '0) begin errors++; $display("FAIL reset_psum pe%0d got %h want 0", p, out_w[p]); end
      checks++;
      if (fcnt[p] !== 4'd0) begin errors++; $display("FAIL reset_fcount pe%0d got %0d want 0", p, fcnt[p]); end
      checks++;
      if (icnt[p] !== 4'd0) begin errors++; $display("FAIL reset_icount pe%0d got %0d want 0", p, icnt[p]); end
    end
    $display("ok reset checked");
  endtask

  task automatic test_single();
    bottom = '0;
    for (int k = 0; k < K; k++) begin
      fen[0] = 1'b1; fv[0] = BW'(k); commit();
      ien[0] = 1'b1; iv[0] = BW'(k); commit();
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      checks++;
      if (rdy_w[0] !== ((j < K) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL single_ready cycle %0d got %b want %b", j + 1, rdy_w[0], (j < K) ? 1'b0 : 1'b1);
      end
    end
    check_out("single", 0);
  endtask

  task automatic test_column();
    do_reset();
    bottom = '0;
    for (int k = 0; k < K; k++) begin
      for (int p = 0; p < NP; p++) begin
        fen[p] = 1'b1; fv[p] = BW'(p + k);
        ien[p] = 1'b1; iv[p] = BW'(p + k);
      end
      commit();
    end
    wait_cycles(6);
    for (int p = 0; p < NP; p++) check_out("column", p);
  endtask

  task automatic test_sliding();
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < NP; p++) begin
        ien[p] = 1'b1; iv[p] = BW'(3 + s + p);
      end
      commit();
      wait_cycles(6);
      check_out("slide", NP - 1);
    end
  endtask

  task automatic test_busy();
    logic [BW-1:0] held;
    for (int p = 0; p < NP; p++) begin
      ien[p] = 1'b1; iv[p] = BW'(7 + p);
    end
    commit();
    tick();
    ien[0] = 1'b1; iv[0] = 16'h1234;
    tick();
    clear_drive();
    wait_cycles(4);
    check_out("busy", NP - 1);
    held = exp_out(NP - 1);
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (rdy_w[0] !== 1'b1 || out_w[NP-1] !== held) begin
        errors++;
        $display("FAIL busy_hold cycle %0d ready %b psum %h want ready 1 psum %h", j, rdy_w[0], out_w[NP-1], held);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bottom = '0;
    for (int k = 0; k < K; k++) begin
      fen[0] = 1'b1; fv[0] = 16'h7FFF;
      ien[0] = 1'b1; iv[0] = 16'h0002;
      commit();
    end
    wait_cycles(6);
    check_out("overflow", 0);
    checks++;
    if (out_w[0] !== 16'hFFFA) begin errors++; $display("FAIL overflow_const got %h want fffa", out_w[0]); end
  endtask

  task automatic test_partial_abort();
    do_reset();
    bottom = '0;
    for (int k = 0; k < 2; k++) begin
      fen[0] = 1'b1; fv[0] = BW'(k + 1);
      ien[0] = 1'b1; iv[0] = BW'(k + 1);
      commit();
    end
    ien[0] = 1'b1; iv[0] = 16'd5; commit();
    wait_cycles(6);
    checks++;
    if (rdy_w[0] !== 1'b1 || out_w[0] !== '0) begin
      errors++;
      $display("FAIL partial ready %b psum %h want ready 1 psum 0", rdy_w[0], out_w[0]);
    end
    fen[0] = 1'b1; fv[0] = 16'd9; commit();
    wait_cycles(2);
    checks++;
    if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL abort_in_mac ready got %b want 0", rdy_w[0]); end
    rstb = 1'b0;
    #1;
    checks++;
    if (rdy_w[0] !== 1'b1 || out_w[0] !== '0 || fcnt[0] !== 4'd0 || icnt[0] !== 4'd0) begin
      errors++;
      $display("FAIL abort_reset ready %b psum %h fcnt %0d icnt %0d want 1 0 0 0", rdy_w[0], out_w[0], fcnt[0], icnt[0]);
    end
    tick();
    rstb = 1'b1;
    tick();
    model_clear();
    $display("ok partial fill and mid-MAC reset checked");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      do_reset();
      bottom = BW'($urandom);
      for (int k = 0; k < K; k++) begin
        for (int p = 0; p < NP; p++) begin
          fen[p] = 1'b1; fv[p] = BW'($urandom);
          ien[p] = 1'b1; iv[p] = BW'($urandom);
        end
        commit();
      end
      wait_cycles(6);
      for (int p = 0; p < NP; p++) check_out("rand_load", p);
      for (int s = 0; s < 3; s++) begin
        for (int p = 0; p < NP; p++) begin
          fen[p] = 1'($urandom_range(0, 1)); fv[p] = BW'($urandom);
          ien[p] = 1'($urandom_range(0, 1)); iv[p] = BW'($urandom);
        end
        commit();
        bottom = BW'($urandom);
        wait_cycles(6);
        check_out("rand_slide", NP - 1);
      end
    end
  endtask

  initial begin
    rstb   = 1'b0;
    bottom = '0;
    for (int p = 0; p < NP; p++) begin
      fv[p] = '0;
      iv[p] = '0;
    end
    clear_drive();
    test_reset();
    test_single();
    test_column();
    test_sliding();
    test_busy();
    test_overflow();
    test_partial_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_pe.md
Name: rs_pe

Overview:
- Row-stationary processing element for a 1-D convolution row.
- Holds a KERNEL_SIZE-tap filter window and a KERNEL_SIZE-tap ifmap sliding window in two small register files.
- Computes the local dot product with a multiply-accumulate loop, then adds the psum arriving from the PE below and drives the sum upward.
- PEs are chained vertically: output_psum of one PE feeds input_psum of the PE above, all running in lockstep.

Parameters:
- BITWIDTH, 16: width of all data, signed two's complement.
- RF_ADDR_WIDTH, 3: register-file address width; depth is 2**RF_ADDR_WIDTH and must be >= KERNEL_SIZE.
- KERNEL_SIZE, 3: number of taps per window.

Ports:
- clk  in  1  clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- ifmap_enable  in  1  write ifmap sample this cycle.
- filter_enable  in  1  write filter weight this cycle.
- ready  out  1  PE can accept writes (idle or result held).
- ifmap  in  BITWIDTH  signed ifmap sample.
- filter  in  BITWIDTH  signed filter weight.
- input_psum  in  BITWIDTH  signed psum from the PE below (0 at the bottom PE).
- output_psum  out  BITWIDTH  signed psum to the PE above.

Behaviour:
- Reset (async, rstb=0):
  - Both register files empty, with count 0 and contents 0.
  - Accumulator 0, state IDLE, dirty flag 0.
  - ready=1, output_psum=0.
- Register files:
  - Each file is an ordered window of up to KERNEL_SIZE entries, oldest = tap 0.
  - A write when not full appends the value.
  - A write when full discards tap 0, shifts every entry down one, and appends at tap KERNEL_SIZE-1 (sliding window).
  - The filter and ifmap files follow the same rule.
  - Writes are accepted only when ready=1; writes while ready=0 are dropped.
  - Simultaneous filter and ifmap writes in the same cycle are both accepted.
  - Any accepted write sets dirty.
- State machine: IDLE, MAC, DONE.
  - IDLE or DONE -> MAC when both files hold KERNEL_SIZE entries and dirty=1, evaluated on the edge after the write is accepted.
  - On that MAC entry: accumulator cleared, tap counter cleared, dirty cleared.
  - MAC: each cycle, acc <= acc + filter[count]*ifmap[count], then count++.
  - MAC -> DONE after KERNEL_SIZE MAC cycles, i.e. on the edge performing the last tap.
  - DONE holds until the next trigger.
- Latency: a write accepted at edge t gives MAC entry at t+1, and DONE with a valid result at edge t+1+KERNEL_SIZE (t+4 for the default).
- ready:
  - ready=1 in IDLE and DONE.
  - ready=0 in MAC.
- output_psum:
  - Combinational: output_psum = acc + input_psum in DONE, else 0.
  - Being combinational lets a lockstep chain of any height settle within the same cycle.
- Arithmetic:
  - Signed BITWIDTH operands.
  - The product is truncated to its low BITWIDTH bits.
  - Sums wrap modulo 2**BITWIDTH with no saturation.
- Reset mid-MAC aborts the computation, and all state returns to reset values.
- No trigger fires with a partially filled file, whatever dirty holds.

Decomposition:
- Shared package: BITWIDTH/RF_ADDR_WIDTH/KERNEL_SIZE defaults and the state encoding (IDLE, MAC, DONE).
- One sub-module, pe_window_rf: parameterised shift-window register file with write enable, full flag, count and indexed read.
- pe_window_rf is instantiated twice, for filter and ifmap.

Test Plan:
- Reset: hold rstb=0, then release -> ready=1, output_psum=0, both files empty.
- Single PE, bottom input_psum=0:
  - Stimulus: load filter 0,1,2 and ifmap 0,1,2 one value per cycle (alternating filter/ifmap), then wait 6 cycles.
  - Required: output_psum=5, and ready=0 only during the 3 MAC cycles.
- Three-PE column, bottom input_psum=0:
  - Stimulus: filters {0,1,2},{1,2,3},{2,3,4}, ifmaps {0,1,2},{1,2,3},{2,3,4}.
  - Required: top output_psum=48 (partials 5/14/29).
- Sliding window on the same column:
  - Stimulus: push one ifmap per PE, (3,4,5), then (4,5,6), (5,6,7), (6,7,8), waiting 6 cycles after each.
  - Required: top output_psum = 66, 84, 102, 120 in turn; filters are unchanged.
- Write while busy: assert ifmap_enable during MAC -> write dropped, result unchanged, no retrigger.
- Overflow wrap: filter 0x7FFF x3 with ifmap 2 x3 -> output equals the wrapped 16-bit sum, with no saturation.
